// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU
// instructions.
//
// A request is accepted in IDLE when start_i is high and flush_i is low. The
// operands, the operation and the destination register are captured at that
// edge.
//   * Divide-by-zero and signed overflow (0x80000000 / -1) finish at once: the
//     unit goes straight to DONE.
//   * Every other request runs 32 restoring shift-subtract iterations in CALC
//     on unsigned magnitudes. It then spends one cycle in DONE, where the
//     register-file write is presented.
//
// Ports
//   clk          in   1   clock, rising edge
//   rst_n        in   1   synchronous active-low reset
//   start_i      in   1   request a divide (looked at only in IDLE)
//   op_i         in   2   funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i   in  32   rs1 operand
//   divisor_i    in  32   rs2 operand
//   rd_addr_i    in   5   destination register
//   flush_i      in   1   kill the operation in flight
//   busy_o       out  1   unit is in CALC or DONE
//   stall_o      out  1   pipeline hold request
//   rd_we_o      out  1   register-file write enable (one-cycle pulse)
//   rd_waddr_o   out  5   register-file write address
//   rd_data_o    out 32   quotient or remainder
// -----------------------------------------------------------------------------
module div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        stall_o,
    output logic        rd_we_o,
    output logic [4:0]  rd_waddr_o,
    output logic [31:0] rd_data_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t      state_q,     state_d;
    logic [4:0]  cnt_q,       cnt_d;
    logic [31:0] rem_q,       rem_d;        // partial remainder
    logic [31:0] quo_q,       quo_d;        // dividend bits shift out, quotient bits shift in
    logic [31:0] dvs_q,       dvs_d;        // divisor magnitude
    logic        op_rem_q,    op_rem_d;     // 1: the result is the remainder
    logic        neg_quo_q,   neg_quo_d;
    logic        neg_rem_q,   neg_rem_d;
    logic [4:0]  rd_addr_q,   rd_addr_d;
    logic        rd_we_q,     rd_we_d;
    logic [4:0]  rd_waddr_q,  rd_waddr_d;
    logic [31:0] rd_data_q,   rd_data_d;

    // Decode of the incoming request.
    logic        is_signed_s;
    logic        dvd_neg_s;
    logic        dvs_neg_s;
    logic [31:0] dvd_mag_s;
    logic [31:0] dvs_mag_s;
    logic        div_zero_s;
    logic        ovf_s;
    logic        special_s;
    logic [31:0] special_res_s;
    logic        accept_s;

    // One restoring iteration, plus the signed final result.
    logic [32:0] shift_s;
    logic        ge_s;
    logic [31:0] rem_sub_s;
    logic [31:0] rem_nx_s;
    logic [31:0] quo_nx_s;
    logic [31:0] quo_fin_s;
    logic [31:0] rem_fin_s;

    // Two's-complement negation, used to turn signed operands into magnitudes
    // and to restore the sign of the results.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return 32'd0 - v;
    endfunction

    // Classify the request: operand signs and magnitudes, and the two cases
    // that finish without iterating.
    always_comb begin
        is_signed_s = ~op_i[0];
        dvd_neg_s   = is_signed_s & dividend_i[31];
        dvs_neg_s   = is_signed_s & divisor_i[31];
        dvd_mag_s   = dvd_neg_s ? neg32(dividend_i) : dividend_i;
        dvs_mag_s   = dvs_neg_s ? neg32(divisor_i)  : divisor_i;
        div_zero_s  = (divisor_i == 32'h0000_0000);
        ovf_s       = is_signed_s & (dividend_i == 32'h8000_0000)
                                  & (divisor_i  == 32'hFFFF_FFFF);
        special_s   = div_zero_s | ovf_s;
        if (op_i[1]) begin
            special_res_s = div_zero_s ? dividend_i : 32'h0000_0000;
        end else begin
            special_res_s = div_zero_s ? 32'hFFFF_FFFF : 32'h8000_0000;
        end
        accept_s = (state_q == ST_IDLE) & start_i & ~flush_i;
    end

    // Restoring step: shift in the next dividend bit and subtract the divisor
    // when it fits. Because rem_q < dvs_q, any difference that is kept is
    // below dvs_q, so a 32-bit wrapping subtraction gives it exactly.
    always_comb begin
        shift_s   = {rem_q, quo_q[31]};
        ge_s      = (shift_s >= {1'b0, dvs_q});
        rem_sub_s = shift_s[31:0] - dvs_q;
        rem_nx_s  = ge_s ? rem_sub_s : shift_s[31:0];
        quo_nx_s  = {quo_q[30:0], ge_s};
        quo_fin_s = neg_quo_q ? neg32(quo_nx_s) : quo_nx_s;
        rem_fin_s = neg_rem_q ? neg32(rem_nx_s) : rem_nx_s;
    end

    // Next-state and next-output logic of the IDLE/CALC/DONE controller.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        op_rem_d   = op_rem_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        rd_addr_d  = rd_addr_q;
        rd_we_d    = 1'b0;
        rd_waddr_d = rd_waddr_q;
        rd_data_d  = rd_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_d     = 5'd0;
                    rem_d     = 32'h0000_0000;
                    quo_d     = dvd_mag_s;
                    dvs_d     = dvs_mag_s;
                    op_rem_d  = op_i[1];
                    neg_quo_d = dvd_neg_s ^ dvs_neg_s;
                    neg_rem_d = dvd_neg_s;
                    rd_addr_d = rd_addr_i;
                    if (special_s) begin
                        state_d    = ST_DONE;
                        rd_data_d  = special_res_s;
                        rd_waddr_d = rd_addr_i;
                        rd_we_d    = (rd_addr_i != 5'd0);
                    end else begin
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = rem_nx_s;
                    quo_d = quo_nx_s;
                    cnt_d = cnt_q + 5'd1;
                    // A count of 31 means this edge does the 32nd iteration.
                    if (cnt_q == 5'd31) begin
                        state_d    = ST_DONE;
                        rd_data_d  = op_rem_q ? rem_fin_s : quo_fin_s;
                        rd_waddr_d = rd_addr_q;
                        rd_we_d    = (rd_addr_q != 5'd0);
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state and output registers; reset is synchronous and takes priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 5'd0;
            rem_q      <= 32'h0000_0000;
            quo_q      <= 32'h0000_0000;
            dvs_q      <= 32'h0000_0000;
            op_rem_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            rd_addr_q  <= 5'd0;
            rd_we_q    <= 1'b0;
            rd_waddr_q <= 5'd0;
            rd_data_q  <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            op_rem_q   <= op_rem_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            rd_addr_q  <= rd_addr_d;
            rd_we_q    <= rd_we_d;
            rd_waddr_q <= rd_waddr_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // The write pulse is killed by a same-cycle flush. All status outputs are
    // held low while reset is asserted, even before the first reset edge.
    always_comb begin
        busy_o     = rst_n & (state_q != ST_IDLE);
        stall_o    = rst_n & ((state_q == ST_CALC) | (accept_s & ~special_s));
        rd_we_o    = rst_n & rd_we_q & ~flush_i;
        rd_waddr_o = rd_waddr_q;
        rd_data_o  = rd_data_q;
    end

endmodule
